// File: rtl/pc_pkg.sv
// pc_pkg: shared state encoding and constants for the PC redirect unit
package pc_pkg;
    typedef enum logic [1:0] {RUN, STALLED, REDIRECT, FAULT} pc_state_t;
    localparam logic [31:0] PC_INC = 32'd4;
    localparam int WORD_SHIFT = 2;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
endpackage

// File: rtl/jump_target_former.sv
// jump_target_former: forms J-format and branch redirect targets from PC+4
module jump_target_former
    import pc_pkg::*;
(
    input  logic [31:0] pc_plus4,
    input  logic [25:0] instr_index,
    input  logic [15:0] branch_offset,
    output logic [31:0] jump_target,
    output logic [31:0] branch_target
);
    assign jump_target = {pc_plus4[31:28], 28'(instr_index) << WORD_SHIFT};
    assign branch_target = pc_plus4 + (32'(signed'(branch_offset)) << WORD_SHIFT);
endmodule

// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit: fetch PC register with stall, prioritised redirects and misaligned-JR fault
module pc_redirect_unit
    import pc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        JumpReq,
    input  logic [25:0] InstrIndex,
    input  logic        BranchReq,
    input  logic [15:0] BranchOffset,
    input  logic        JumpRegReq,
    input  logic [31:0] RegTarget,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        FetchValid,
    output logic        Flush,
    output logic        AddrErr
);
    pc_state_t state, next_state;
    logic [31:0] pc, pc_plus4, next_pc, jump_target, branch_target;
    logic active;

    jump_target_former u_former (
        .pc_plus4(pc_plus4),
        .instr_index(InstrIndex),
        .branch_offset(BranchOffset),
        .jump_target(jump_target),
        .branch_target(branch_target)
    );

    assign active = (state == RUN) || (state == STALLED);

    // REDIRECT holds the target so it is refetched once the squash cycle ends
    always_comb begin
        next_state = state;
        next_pc = pc;
        if (Stall && state != FAULT) begin
            next_state = STALLED;
        end else if (active) begin
            if (JumpRegReq) begin
                next_state = (RegTarget[1:0] != 2'b00) ? FAULT : REDIRECT;
                next_pc = (RegTarget[1:0] != 2'b00) ? pc : RegTarget;
            end else if (JumpReq || BranchReq) begin
                next_state = REDIRECT;
                next_pc = JumpReq ? jump_target : branch_target;
            end else begin
                next_state = RUN;
                next_pc = pc_plus4;
            end
        end else if (state == REDIRECT) begin
            next_state = RUN;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= RUN;
            pc <= RESET_PC;
            pc_plus4 <= RESET_PC + PC_INC;
        end else begin
            state <= next_state;
            pc <= next_pc;
            pc_plus4 <= next_pc + PC_INC;
        end
    end

    assign PC = pc;
    assign PCPlus4 = pc_plus4;
    assign FetchValid = active && !Stall;
    assign Flush = (state == REDIRECT);
    assign AddrErr = (state == FAULT);
endmodule

// File: tb/tb_pc_redirect_unit.sv
// tb_pc_redirect_unit: directed scoreboard bench for pc_redirect_unit
module tb_pc_redirect_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        jump_req = 1'b0;
    logic [25:0] instr_index = '0;
    logic        branch_req = 1'b0;
    logic [15:0] branch_offset = '0;
    logic        jump_reg_req = 1'b0;
    logic [31:0] reg_target = '0;
    logic [31:0] pc, pc_plus4, pc_b, pc_plus4_b;
    logic        fetch_valid, flush, addr_err, fetch_valid_b, flush_b, addr_err_b;
    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic        fv;
        logic        fl;
        logic        ae;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    pc_redirect_unit dut (
        .Clk(clk), .Reset(reset), .Stall(stall),
        .JumpReq(jump_req), .InstrIndex(instr_index),
        .BranchReq(branch_req), .BranchOffset(branch_offset),
        .JumpRegReq(jump_reg_req), .RegTarget(reg_target),
        .PC(pc), .PCPlus4(pc_plus4), .FetchValid(fetch_valid),
        .Flush(flush), .AddrErr(addr_err)
    );

    pc_redirect_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .Clk(clk), .Reset(reset), .Stall(1'b0),
        .JumpReq(1'b0), .InstrIndex(26'd0),
        .BranchReq(1'b0), .BranchOffset(16'd0),
        .JumpRegReq(1'b0), .RegTarget(32'd0),
        .PC(pc_b), .PCPlus4(pc_plus4_b), .FetchValid(fetch_valid_b),
        .Flush(flush_b), .AddrErr(addr_err_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Push this cycle's expectation, sample just after input drive, pop and compare, then clock
    task automatic cyc(input string tag, input logic [31:0] epc, input logic efv, input logic efl, input logic eae);
        exp_t e;
        sb.push_back('{tag, epc, efv, efl, eae});
        #1;
        e = sb.pop_front();
        chk({e.tag, "_pc"}, pc, e.pc);
        chk({e.tag, "_pc4"}, pc_plus4, e.pc + 32'd4);
        chk({e.tag, "_fv"}, 32'(fetch_valid), 32'(e.fv));
        chk({e.tag, "_flush"}, 32'(flush), 32'(e.fl));
        chk({e.tag, "_aerr"}, 32'(addr_err), 32'(e.ae));
        @(posedge clk);
        #1;
        jump_req = 1'b0;
        branch_req = 1'b0;
        jump_reg_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("wrap_rst_pc", pc_b, 32'hFFFF_FFFC);
        chk("wrap_rst_pc4", pc_plus4_b, 32'h0000_0000);
        cyc("rst", 32'h0, 1, 0, 0);
        chk("wrap_pc", pc_b, 32'h0000_0000);
        chk("wrap_aerr", 32'(addr_err_b), 32'd0);
        chk("wrap_fv", 32'(fetch_valid_b), 32'd1);
        cyc("free1", 32'h4, 1, 0, 0);
        cyc("free2", 32'h8, 1, 0, 0);
        cyc("free3", 32'hC, 1, 0, 0);
        jump_reg_req = 1'b1; reg_target = 32'h1000_0010;
        cyc("jr_a", 32'h10, 1, 0, 0);
        cyc("redir_a", 32'h1000_0010, 0, 1, 0);
        jump_req = 1'b1; instr_index = 26'h0000040;
        cyc("jump", 32'h1000_0010, 1, 0, 0);
        branch_req = 1'b1; branch_offset = 16'h0003;
        cyc("jump_redir", 32'h1000_0100, 0, 1, 0);
        cyc("jump_run", 32'h1000_0100, 1, 0, 0);
        jump_reg_req = 1'b1; reg_target = 32'h100;
        cyc("jr_b", 32'h1000_0104, 1, 0, 0);
        cyc("redir_b", 32'h100, 0, 1, 0);
        branch_req = 1'b1; branch_offset = 16'hFFFE;
        cyc("br_neg", 32'h100, 1, 0, 0);
        cyc("br_neg_redir", 32'hFC, 0, 1, 0);
        jump_reg_req = 1'b1; reg_target = 32'h100;
        cyc("jr_c", 32'hFC, 1, 0, 0);
        cyc("redir_c", 32'h100, 0, 1, 0);
        branch_req = 1'b1; branch_offset = 16'h0003;
        cyc("br_pos", 32'h100, 1, 0, 0);
        cyc("br_pos_redir", 32'h110, 0, 1, 0);
        jump_reg_req = 1'b1; reg_target = 32'h40;
        cyc("jr_d", 32'h110, 1, 0, 0);
        cyc("redir_d", 32'h40, 0, 1, 0);
        stall = 1'b1;
        cyc("stall1", 32'h40, 0, 0, 0);
        jump_req = 1'b1; instr_index = 26'h0000123;
        cyc("stall2", 32'h40, 0, 0, 0);
        cyc("stall3", 32'h40, 0, 0, 0);
        stall = 1'b0;
        cyc("release", 32'h40, 1, 0, 0);
        cyc("after_release", 32'h44, 1, 0, 0);
        reset = 1'b1; stall = 1'b1; jump_req = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0; stall = 1'b0;
        jump_reg_req = 1'b1; reg_target = 32'h200;
        jump_req = 1'b1; instr_index = 26'h3FFFFFF;
        cyc("prio", 32'h0, 1, 0, 0);
        cyc("prio_redir", 32'h200, 0, 1, 0);
        cyc("prio_run", 32'h200, 1, 0, 0);
        jump_reg_req = 1'b1; reg_target = 32'h202;
        cyc("jr_misalign", 32'h204, 1, 0, 0);
        cyc("fault1", 32'h204, 0, 0, 1);
        jump_req = 1'b1; instr_index = 26'h0000010;
        cyc("fault2", 32'h204, 0, 0, 1);
        stall = 1'b1;
        cyc("fault3", 32'h204, 0, 0, 1);
        stall = 1'b0; reset = 1'b1;
        cyc("fault_rst", 32'h204, 0, 0, 1);
        reset = 1'b0;
        jump_reg_req = 1'b1; reg_target = 32'h80;
        cyc("rst_from_fault", 32'h0, 1, 0, 0);
        reset = 1'b1;
        cyc("redir_rst", 32'h80, 0, 1, 0);
        reset = 1'b0;
        cyc("post_rst", 32'h0, 1, 0, 0);
        cyc("post_rst_run", 32'h4, 1, 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
